// File: rtl/bcd_decoder_if.sv
// Digit/control bundle between the counting logic and one seven-segment decoder.
interface bcd_decoder_if;
    logic       en;
    logic [3:0] w;
    logic       blank;
    logic       lamp_test;
    logic [6:0] bcd;
    logic       err;

    modport master (
        output en,
        output w,
        output blank,
        output lamp_test,
        input  bcd,
        input  err
    );

    modport slave (
        input  en,
        input  w,
        input  blank,
        input  lamp_test,
        output bcd,
        output err
    );
endinterface

// File: rtl/bcd_decoder.sv
// Registered BCD-to-seven-segment decoder with lamp test, blanking and invalid-code flag.
// Segment bit order is {g,f,e,d,c,b,a}; ACTIVE_LOW selects common-anode drive.
module bcd_decoder #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input logic          clk,
    input logic          rst,
    bcd_decoder_if.slave bus
);

    localparam logic [6:0] SegOff = ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [6:0] w_digit_on;
    logic       w_digit_valid;
    logic [6:0] w_on_next;
    logic       w_err_next;

    logic [6:0] r_bcd;
    logic       r_err;

    // Logical segment pattern, 1 = lit.
    always_comb begin
        w_digit_on    = 7'h00;
        w_digit_valid = 1'b1;
        case (bus.w)
            4'd0:    w_digit_on = 7'b0111111;
            4'd1:    w_digit_on = 7'b0000110;
            4'd2:    w_digit_on = 7'b1011011;
            4'd3:    w_digit_on = 7'b1001111;
            4'd4:    w_digit_on = 7'b1100110;
            4'd5:    w_digit_on = 7'b1101101;
            4'd6:    w_digit_on = 7'b1111101;
            4'd7:    w_digit_on = 7'b0000111;
            4'd8:    w_digit_on = 7'b1111111;
            4'd9:    w_digit_on = 7'b1101111;
            default: begin
                w_digit_on    = 7'h00;
                w_digit_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_on_next  = 7'h00;
        w_err_next = 1'b0;
        if (bus.lamp_test) begin
            w_on_next = 7'h7F;
        end else if (bus.blank) begin
            w_on_next = 7'h00;
        end else begin
            w_on_next  = w_digit_on;
            w_err_next = ~w_digit_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd <= SegOff;
            r_err <= 1'b0;
        end else if (bus.en) begin
            r_bcd <= ACTIVE_LOW ? ~w_on_next : w_on_next;
            r_err <= w_err_next;
        end
    end

    assign bus.bcd = r_bcd;
    assign bus.err = r_err;

endmodule

// File: tb/tb_bcd_decoder.sv
// Self-checking bench: both polarities driven in parallel against a table-driven model.
module tb_bcd_decoder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bcd_decoder_if u_if_lo ();
    bcd_decoder_if u_if_hi ();

    bcd_decoder #(.ACTIVE_LOW(1'b1)) u_dut_lo (.clk(clk), .rst(rst), .bus(u_if_lo));
    bcd_decoder #(.ACTIVE_LOW(1'b0)) u_dut_hi (.clk(clk), .rst(rst), .bus(u_if_hi));

    int n_checks = 0;
    int n_errors = 0;

    // Logical lit-segment patterns, gfedcba.
    logic [6:0] seg_on [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    // Hand-written common-anode drive values for digits 0..9.
    logic [6:0] lit_lo [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic [6:0] m_on;
    logic       m_err;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_on    = 7'h00;
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else if (u_if_lo.en) begin
            m_err = 1'b0;
            if (u_if_lo.lamp_test)   m_on = 7'h7F;
            else if (u_if_lo.blank)  m_on = 7'h00;
            else if (u_if_lo.w > 9) begin
                m_on  = 7'h00;
                m_err = 1'b1;
            end else                 m_on = seg_on[u_if_lo.w];
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_bcd_lo", {1'b0, u_if_lo.bcd}, {1'b0, ~m_on});
            chk("model_bcd_hi", {1'b0, u_if_hi.bcd}, {1'b0, m_on});
            chk("model_err_lo", {7'b0, u_if_lo.err}, {7'b0, m_err});
            chk("model_err_hi", {7'b0, u_if_hi.err}, {7'b0, m_err});
        end
    end

    // Set inputs on both DUTs, then advance past one rising edge.
    task automatic apply(input logic r, input logic e, input logic [3:0] d,
                         input logic b, input logic lt);
        rst               = r;
        u_if_lo.en        = e;
        u_if_lo.w         = d;
        u_if_lo.blank     = b;
        u_if_lo.lamp_test = lt;
        u_if_hi.en        = e;
        u_if_hi.w         = d;
        u_if_hi.blank     = b;
        u_if_hi.lamp_test = lt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        apply(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Reset sweep
        apply(1'b1, 1'b1, 4'd8, 1'b0, 1'b0);
        chk("reset_bcd", {1'b0, u_if_lo.bcd}, 8'h7F);
        chk("reset_err", {7'b0, u_if_lo.err}, 8'h00);
        apply(1'b0, 1'b1, 4'd8, 1'b0, 1'b0);
        chk("post_reset_8", {1'b0, u_if_lo.bcd}, 8'h00);

        // Full decode
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b1, 4'(i), 1'b0, 1'b0);
            chk($sformatf("digit_%0d", i), {1'b0, u_if_lo.bcd}, {1'b0, lit_lo[i]});
            chk($sformatf("digit_err_%0d", i), {7'b0, u_if_lo.err}, 8'h00);
        end

        // Invalid codes
        for (int i = 10; i < 16; i++) begin
            apply(1'b0, 1'b1, 4'(i), 1'b0, 1'b0);
            chk($sformatf("invalid_bcd_%0d", i), {1'b0, u_if_lo.bcd}, 8'h7F);
            chk($sformatf("invalid_err_%0d", i), {7'b0, u_if_lo.err}, 8'h01);
        end
        apply(1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        chk("recover_bcd", {1'b0, u_if_lo.bcd}, 8'h30);
        chk("recover_err", {7'b0, u_if_lo.err}, 8'h00);

        // Override priority
        apply(1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
        chk("blank", {1'b0, u_if_lo.bcd}, 8'h7F);
        apply(1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
        chk("lamp_over_blank", {1'b0, u_if_lo.bcd}, 8'h00);
        apply(1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        chk("drop_overrides", {1'b0, u_if_lo.bcd}, 8'h12);
        apply(1'b0, 1'b1, 4'd12, 1'b0, 1'b0);
        chk("invalid_before_lt", {7'b0, u_if_lo.err}, 8'h01);
        apply(1'b0, 1'b1, 4'd12, 1'b0, 1'b1);
        chk("lt_clears_err", {7'b0, u_if_lo.err}, 8'h00);
        apply(1'b0, 1'b1, 4'd12, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 4'd12, 1'b1, 1'b0);
        chk("blank_clears_err", {7'b0, u_if_lo.err}, 8'h00);

        // Enable hold
        apply(1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
        chk("hold_setup", {1'b0, u_if_lo.bcd}, 8'h24);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 4'd7, 1'b0, 1'b0);
            chk($sformatf("hold_%0d", i), {1'b0, u_if_lo.bcd}, 8'h24);
        end
        apply(1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
        chk("hold_release", {1'b0, u_if_lo.bcd}, 8'h78);
        apply(1'b0, 1'b1, 4'd14, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
        chk("hold_err", {7'b0, u_if_lo.err}, 8'h01);

        // Reset with en=0 mid-operation
        apply(1'b1, 1'b0, 4'd3, 1'b0, 1'b1);
        chk("reset_no_en_bcd", {1'b0, u_if_lo.bcd}, 8'h7F);
        chk("reset_no_en_err", {7'b0, u_if_lo.err}, 8'h00);

        // Polarity, ACTIVE_LOW=0 instance
        apply(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        chk("hi_digit_1", {1'b0, u_if_hi.bcd}, 8'h06);
        apply(1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
        chk("hi_reset", {1'b0, u_if_hi.bcd}, 8'h00);
        apply(1'b0, 1'b1, 4'd1, 1'b0, 1'b1);
        chk("hi_lamp_test", {1'b0, u_if_hi.bcd}, 8'h7F);
        apply(1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
        chk("hi_digit_9", {1'b0, u_if_hi.bcd}, 8'h6F);

        apply(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
